// File: rtl/ethpipe_csr.sv
// ethpipe_csr: BAR0 control/status register file for the EtherPIPE datapath.
// Bus words are byte-swapped; all registers are held in logical byte order internally.
module ethpipe_csr #(
    parameter int NCH   = 2,
    parameter int NTS   = 7,
    parameter int PTR_W = 14
) (
    input  logic                  clk_125,
    input  logic                  sys_rst_n,
    input  logic                  slv_ce_i,
    input  logic                  slv_we_i,
    input  logic [8:1]            slv_adr_i,
    input  logic [15:0]           slv_dat_i,
    input  logic [1:0]            slv_sel_i,
    output logic [15:0]           slv_dat_o,
    output logic [63:0]           global_counter,
    output logic [21:2]           dma_length,
    output logic [NCH*30-1:0]     dma_addr_start,
    input  logic [NCH*30-1:0]     dma_addr_cur,
    output logic [NCH-1:0]        dma_load,
    output logic [NCH*PTR_W-1:0]  tx_wr_ptr,
    input  logic [NCH*PTR_W-1:0]  tx_rd_ptr,
    input  logic [NCH*7-1:0]      ts_req,
    output logic [NCH*NTS*48-1:0] local_time,
    input  logic [NCH-1:0]        intr_src,
    output logic                  sys_intr
);

    logic [7:0]       adr;
    logic             rd_en;
    logic             wr_en;
    logic [15:0]      wdata;
    logic [15:0]      wmask;
    logic [15:0]      rd_val;
    logic [47:0]      cnt_shadow;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   w1c_clr;
    logic             enable;
    logic [29:0]      addr_start [NCH];
    logic [15:0]      cur_shadow [NCH];
    logic [PTR_W-1:0] wr_ptr     [NCH];
    logic [47:0]      lt_q       [NCH][NTS];
    logic [31:0]      lt_shadow  [NCH];
    logic [NTS-1:0]   cap_sel    [NCH];
    logic [47:0]      cap_val;
    logic             lt_blk;
    logic [2:0]       lt_c;
    logic             ts_unused;

    assign adr       = slv_adr_i;
    assign rd_en     = slv_ce_i & ~slv_we_i;
    assign wr_en     = slv_ce_i & slv_we_i;
    assign wdata     = {slv_dat_i[7:0], slv_dat_i[15:8]};
    assign wmask     = {{8{slv_sel_i[0]}}, {8{slv_sel_i[1]}}};
    assign w1c_clr   = (wr_en && adr == 8'h08 && slv_sel_i[1]) ? wdata[NCH-1:0] : '0;
    assign lt_blk    = (adr[7:6] == 2'b01) || (adr[7:6] == 2'b10);
    assign lt_c      = adr[7:5] - 3'd2;
    assign cap_val   = global_counter[47:0] - 48'd1;
    assign ts_unused = ^ts_req;

    // Lowest set request bit wins: x & -x isolates it.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign dma_addr_start[c*30 +: 30]   = addr_start[c];
        assign tx_wr_ptr[c*PTR_W +: PTR_W]  = wr_ptr[c];
        assign cap_sel[c] = ts_req[c*7 +: NTS] & (~ts_req[c*7 +: NTS] + NTS'(1));
        for (genvar s = 0; s < NTS; s++) begin : g_slot
            assign local_time[(c*NTS+s)*48 +: 48] = lt_q[c][s];
        end
    end

    always_comb begin
        rd_val = '0;
        case (adr)
            8'h00: rd_val = {8'(NCH), 8'(NTS)};
            8'h02: rd_val = global_counter[15:0];
            8'h03: rd_val = cnt_shadow[15:0];
            8'h04: rd_val = cnt_shadow[31:16];
            8'h05: rd_val = cnt_shadow[47:32];
            8'h08: begin
                rd_val[7]       = enable;
                rd_val[NCH-1:0] = pending;
            end
            8'h0a: rd_val = {dma_length[15:2], 2'b00};
            8'h0b: rd_val = {10'd0, dma_length[21:16]};
            default: rd_val = '0;
        endcase
        for (int c = 0; c < NCH; c++) begin
            if (adr[7:4] == 4'h1 && adr[3:2] == 2'(c)) begin
                case (adr[1:0])
                    2'd0:    rd_val = {addr_start[c][13:0], 2'b00};
                    2'd1:    rd_val = addr_start[c][29:14];
                    2'd2:    rd_val = {dma_addr_cur[c*30 +: 14], 2'b00};
                    default: rd_val = cur_shadow[c];
                endcase
            end
            if (adr == 8'h20 + 8'(c))
                rd_val = 16'(wr_ptr[c]);
            if (adr == 8'h28 + 8'(c))
                rd_val = 16'(tx_rd_ptr[c*PTR_W +: PTR_W]);
            for (int s = 0; s < NTS; s++) begin
                if (lt_blk && lt_c == 3'(c) && adr[4:2] == 3'(s)) begin
                    case (adr[1:0])
                        2'd0:    rd_val = lt_q[c][s][15:0];
                        2'd1:    rd_val = lt_shadow[c][15:0];
                        2'd2:    rd_val = lt_shadow[c][31:16];
                        default: rd_val = '0;
                    endcase
                end
            end
        end
    end

    // Snapshots load on the same edge that returns the low word, keeping multi-word reads coherent.
    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slv_dat_o      <= '0;
            global_counter <= '0;
            cnt_shadow     <= '0;
            pending        <= '0;
            enable         <= 1'b0;
            sys_intr       <= 1'b0;
            dma_length     <= 20'h04000;
            dma_load       <= '0;
            for (int c = 0; c < NCH; c++) begin
                addr_start[c] <= 30'((32'h1000_0000 + 32'(c) * 32'h0010_0000) >> 2);
                cur_shadow[c] <= '0;
                wr_ptr[c]     <= '0;
                lt_shadow[c]  <= '0;
                for (int s = 0; s < NTS; s++)
                    lt_q[c][s] <= '0;
            end
        end else begin
            global_counter <= global_counter + 64'd1;
            dma_load       <= '0;
            pending        <= (pending & ~w1c_clr) | intr_src;
            sys_intr       <= enable & (|pending);
            if (rd_en)
                slv_dat_o <= {rd_val[7:0], rd_val[15:8]};
            if (rd_en && adr == 8'h02)
                cnt_shadow <= global_counter[63:16];
            if (wr_en && adr == 8'h08 && slv_sel_i[1])
                enable <= wdata[7];
            if (wr_en && adr == 8'h0a) begin
                dma_length[15:2] <= (dma_length[15:2] & ~wmask[15:2]) | (wdata[15:2] & wmask[15:2]);
                dma_load         <= '1;
            end
            if (wr_en && adr == 8'h0b) begin
                dma_length[21:16] <= (dma_length[21:16] & ~wmask[5:0]) | (wdata[5:0] & wmask[5:0]);
                dma_load          <= '1;
            end
            for (int c = 0; c < NCH; c++) begin
                if (wr_en && adr == 8'h10 + 8'(4 * c)) begin
                    addr_start[c][13:0] <= (addr_start[c][13:0] & ~wmask[15:2]) | (wdata[15:2] & wmask[15:2]);
                    dma_load[c]         <= 1'b1;
                end
                if (wr_en && adr == 8'h11 + 8'(4 * c)) begin
                    addr_start[c][29:14] <= (addr_start[c][29:14] & ~wmask) | (wdata & wmask);
                    dma_load[c]          <= 1'b1;
                end
                if (rd_en && adr == 8'h12 + 8'(4 * c))
                    cur_shadow[c] <= dma_addr_cur[c*30+14 +: 16];
                if (wr_en && adr == 8'h20 + 8'(c))
                    wr_ptr[c] <= (wr_ptr[c] & ~wmask[PTR_W-1:0]) | (wdata[PTR_W-1:0] & wmask[PTR_W-1:0]);
                for (int s = 0; s < NTS; s++) begin
                    if (cap_sel[c][s])
                        lt_q[c][s] <= cap_val;
                    if (rd_en && lt_blk && lt_c == 3'(c) && adr[4:2] == 3'(s) && adr[1:0] == 2'd0)
                        lt_shadow[c] <= lt_q[c][s][47:16];
                end
            end
        end
    end

endmodule

// File: doc/ethpipe_csr.md
# ethpipe_csr

Parametrised control/status register file for the EtherPIPE datapath, replacing hand-expanded per-PHY register decode with NCH identical channel banks. It sits on the PCIe slave bus behind BAR0 and owns the following state:

- the free-running global counter;
- DMA ring configuration;
- TX slot write pointers;
- per-channel local-time capture slots;
- a maskable write-1-to-clear interrupt status.

Over the previous decode it adds coherent multi-word reads, interrupt masking/clearing and range-checked channel/slot decode.

## Interface
Parameters:
- NCH, 2, number of channels (1..4)
- NTS, 7, local-time slots per channel (1..7)
- PTR_W, 14, TX slot pointer width (≤16)

Ports (clock and reset first):
- clk_125  in  1  system clock
- sys_rst_n  in  1  asynchronous, active-low reset
- slv_ce_i  in  1  BAR0 access strobe, one cycle per 16-bit access
- slv_we_i  in  1  1 = write, 0 = read
- slv_adr_i  in  [8:1]  word address
- slv_dat_i  in  16  write data, byte-swapped
- slv_sel_i  in  2  byte enables; [1] = logical low byte (slv_dat_i[15:8])
- slv_dat_o  out  16  registered read data, byte-swapped
- global_counter  out  64  free-running counter
- dma_length  out  [21:2]  shared ring length
- dma_addr_start  out  NCH*30  per-channel ring base, bits [31:2]
- dma_addr_cur  in  NCH*30  per-channel DMA current address
- dma_load  out  NCH  one-cycle reload pulse per channel
- tx_wr_ptr  out  NCH*PTR_W  host-written TX pointers
- tx_rd_ptr  in  NCH*PTR_W  sender read pointers
- ts_req  in  NCH*7  local-time capture requests; bits ≥ NTS ignored
- local_time  out  NCH*NTS*48  captured timestamps
- intr_src  in  NCH  per-channel interrupt event pulses
- sys_intr  out  1  level interrupt to PCIe core

## Operation
Byte order on the bus: swap(V) = {V[7:0], V[15:8]}. Every read returns swap of the logical value. A write updates logical byte [7:0] when slv_sel_i[1] and byte [15:8] when slv_sel_i[0].

Address map (word addresses):
- 0x00 RO: {NCH[7:0], NTS[7:0]} (logical high, low).
- 0x02..0x05 RO: global_counter words 0..3.
  - A read of 0x02 snapshots bits [63:16] into a shadow.
  - Reads of 0x03..0x05 return the shadow.
- 0x08 status:
  - bits [NCH-1:0] pending interrupts, W1C;
  - bit 7 interrupt enable, RW;
  - other bits read 0.
- 0x0a/0x0b: dma_length [15:2] / [21:16]. A write pulses all dma_load bits.
- 0x10+4c+{0,1}: dma_addr_start lo [15:2] / hi [31:16] for channel c. A write pulses dma_load[c].
- 0x10+4c+2 RO: dma_addr_cur lo; the same read snapshots the hi word.
- 0x10+4c+3 RO: the hi-word snapshot.
- 0x20+c: tx_wr_ptr RW. 0x28+c: tx_rd_ptr RO. Both zero-extended to 16 bits.
- 0x40+32c+4s+w, w∈{0,1,2}: local_time[c][s] bits [16w+15:16w].
  - A read with w=0 snapshots the full 48 bits.
  - Reads with w=1,2 return the snapshot.

Decode rules:
- Any address that is unmapped, or has c ≥ NCH or s ≥ NTS, reads 0 and ignores writes.
- Writes to RO registers are ignored.

Global counter:
- Increments by 1 every cycle.
- Wraps from 2^64−1 to 0.

Local-time capture:
- Per channel per cycle, only the lowest-indexed asserted ts_req bit is served.
- That slot loads global_counter[47:0] − 1, mod 2^48, using the counter value present in that cycle.

Interrupts:
- A 1 on intr_src[c] sets pending[c].
- A W1C write to 0x08 clears the selected pending bits.
- If a set and a clear of the same bit occur in the same cycle, the set wins.
- sys_intr = enable & |pending.

## Timing
- Reset values:
  - slv_dat_o, global_counter, tx_wr_ptr, local_time, pending, enable, dma_load, sys_intr, all shadows: 0;
  - dma_length = 0x4000 (64 KiB);
  - dma_addr_start[c] = (0x1000_0000 + c·0x10_0000) >> 2.
- Reads: slv_dat_o is valid on the cycle after slv_ce_i and holds its value until the next read.
- Writes: the register updates on the clock edge where slv_ce_i=1.
- dma_load is high exactly one cycle, in the cycle after the write, and low otherwise.
- A snapshot is taken in the same edge as the low-word read, so the low word and the shadowed words are mutually coherent.
- A capture request in cycle t is visible on local_time in cycle t+1.
- sys_intr follows pending/enable with one register stage.
- Reset asserted mid-access aborts the access; no partial byte is written after release.

## Test plan
- Reset release, read 0x00 with NCH=2, NTS=7 → slv_dat_o = 0x0702; read 0x10 → 0x0000; read 0x11 → 0x0010 (0x1000 byte-swapped).
- Read 0x02..0x05 with the counter rolling past 0x0000_FFFF between reads → words form one coherent 64-bit value.
- ts_req[0] and ts_req[3] high together on channel 1 at counter 0x1234 → local_time[1][0] = 0x1233, slot 3 unchanged; read 0x60,0x61,0x62 → 0x3312, 0x0000, 0x0000.
- Write 0x14 with sel=2'b10, data 0xFC00 → dma_addr_start[1][7:2] = 0x3F, dma_load = 2'b10 for exactly one cycle.
- Enable interrupts, pulse intr_src[0] → sys_intr = 1; W1C bit 0 in the same cycle as a new intr_src[0] pulse → pending stays 1.
- NCH=2: write 0x12 and 0x22, read 0x5C and 0x90 → no state change, both reads return 0.
